uart_boot_ctrl: RTL and testbench
=================================

UART_BOOT_CTRL -- requirements
Module: uart_boot_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter ADDR_W, default 12, SHALL set the ROM word-address width (4096 words).
REQ-003 Parameter TIMEOUT, default 200000, SHALL set the idle cycles that end a download (about 4 byte-times at 5208 clk/bit).
REQ-004 Parameter HOLD, default 16, SHALL set the cycles cpu_rst stays high after download ends.
REQ-005 Ports SHALL be as follows:
  clk  in  1  system clock
  rst  in  1  synchronous active-high reset
  load_en  in  1  permits downloads; when 0, rx bytes are ignored
  rx_valid  in  1  one-cycle strobe: rx_data holds a received UART byte
  rx_data  in  8  received byte
  rom_we  out  1  one-cycle instruction-ROM write strobe
  rom_addr  out  ADDR_W  ROM word address
  rom_wdata  out  32  assembled instruction word
  cpu_rst  out  1  active-high hold/reset to the CPU core
  busy  out  1  download in progress (any state other than IDLE)
  word_cnt  out  ADDR_W+1  words written in the current or last download
  err  out  1  sticky error: partial word at timeout, or overflow

Function
REQ-006 The state machine SHALL have three states: IDLE, RECV and RELEASE.
REQ-007 IDLE->RECV SHALL occur on rx_valid&load_en; that byte is byte 0 of word 0, and word_cnt, rom_addr and err clear to 0 in the same edge.
REQ-008 In RECV, bytes SHALL be assembled MSB first: byte 0 -> [31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0].
REQ-009 A 2-bit byte counter SHALL wrap 3->0; on the 4th byte, rom_we SHALL pulse high on the next cycle only, with rom_wdata set to the word and rom_addr set to the current index.
REQ-010 The cycle after rom_we, rom_addr and word_cnt SHALL increment by 1.
REQ-011 An idle counter SHALL reset on every accepted byte; when it reaches TIMEOUT-1 in RECV, the state SHALL go to RELEASE.
REQ-012 If the byte counter is nonzero at timeout, the partial word SHALL be discarded and err SHALL be set.
REQ-013 Overflow: once word_cnt = 2^ADDR_W, further complete words SHALL NOT write (no rom_we), err SHALL be set, and rom_addr SHALL NOT wrap.
REQ-014 load_en falling during RECV SHALL NOT abort the download; bytes are still accepted until timeout.
REQ-015 RELEASE SHALL last exactly HOLD cycles, ignore rx_valid, then go to IDLE.
REQ-016 cpu_rst SHALL be high in RECV and RELEASE and low in IDLE; it SHALL deassert on the first IDLE cycle.
REQ-017 If rx_valid coincides with the rom_we cycle, the byte SHALL be accepted as byte 0 of the next word, and the write SHALL be unaffected.
REQ-018 rom_we SHALL never be high outside RECV.

Reset
REQ-019 On rst: state=IDLE, rom_we=0, rom_addr=0, rom_wdata=0, word_cnt=0, err=0, busy=0, cpu_rst=1 while rst is high, and all counters=0.
REQ-020 rst during RECV or RELEASE SHALL abort immediately with no further rom_we; the ROM contents already written are kept.

Structure
REQ-021 The state encoding and the TIMEOUT/HOLD defaults SHALL live in the shared SoC defines package.
REQ-022 One sub-module, boot_timer (a loadable down-counter with a done flag), SHALL be reused for both the idle timeout and the HOLD count.
REQ-023 The block SHALL sit between uart_rx and the instruction ROM's write port inside the SoC top.

Verification
REQ-024 Send 16 bytes encoding 0x00100093, 0x00200113, 0x001080B3, 0xFE208EE3 -> expect 4 rom_we pulses at addr 0..3 with those words, then word_cnt=4, err=0, and cpu_rst low HOLD cycles after the timeout.
REQ-025 Send 6 bytes then go silent -> expect 1 write (addr 0), err=1, and word_cnt=1 after the timeout.
REQ-026 With ADDR_W=2, send 5 words -> expect writes to addr 0..3 only, err=1, and word_cnt=4.
REQ-027 Assert rst after 9 bytes -> expect no further rom_we, state IDLE, and cpu_rst low on the first cycle after rst drops.
REQ-028 With load_en=0, send 4 bytes -> expect no rom_we, busy=0, and cpu_rst=0 throughout.
REQ-029 Force rx_valid in the same cycle as rom_we -> expect that byte to appear in [31:24] of the next word.

Source files
------------

// File: rtl/uart_boot_ctrl_pkg.sv
// uart_boot_ctrl_pkg: shared state encoding and timing defaults for the UART boot loader
package uart_boot_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RECV, RELEASE} state_t;
  localparam int TIMEOUT_DEF = 200000;
  localparam int HOLD_DEF = 16;
endpackage

// File: rtl/uart_boot_ctrl_boot_timer.sv
// boot_timer: loadable down-counter; done is high while the count is zero
module boot_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/uart_boot_ctrl.sv
// uart_boot_ctrl: assembles UART bytes MSB-first into 32-bit words and writes them to the instruction ROM while holding the CPU in reset
module uart_boot_ctrl
  import uart_boot_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int HOLD = HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic [ADDR_W:0]   word_cnt,
  output logic              err
);
  localparam int TW = $clog2((TIMEOUT > HOLD ? TIMEOUT : HOLD) + 1);
  state_t state, nxt;
  logic accept, timeout, tmr_done;
  logic [1:0] byte_cnt;
  logic [31:0] shreg;
  boot_timer #(.W(TW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(accept || timeout),
    .val(timeout ? TW'(HOLD - 1) : TW'(TIMEOUT - 1)),
    .done(tmr_done)
  );
  always_comb begin
    accept = rx_valid && ((state == IDLE && load_en) || state == RECV);
    timeout = state == RECV && tmr_done && !accept;
    nxt = (state == IDLE && accept) ? RECV :
          timeout ? RELEASE :
          (state == RELEASE && tmr_done) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  assign busy = state != IDLE;
  assign cpu_rst = rst || busy;
  // word_cnt[ADDR_W] set means the ROM is full; rom_addr saturates instead of wrapping
  always_ff @(posedge clk)
    if (rst) begin
      rom_we <= 1'b0;
      rom_addr <= '0;
      rom_wdata <= '0;
      word_cnt <= '0;
      err <= 1'b0;
      byte_cnt <= '0;
      shreg <= '0;
    end else begin
      rom_we <= 1'b0;
      if (rom_we) begin
        word_cnt <= word_cnt + 1'b1;
        if (rom_addr != '1) rom_addr <= rom_addr + 1'b1;
      end
      if (state == IDLE && accept) begin
        word_cnt <= '0;
        rom_addr <= '0;
        err <= 1'b0;
      end
      if (accept) begin
        shreg <= {shreg[23:0], rx_data};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          if (word_cnt[ADDR_W]) err <= 1'b1;
          else begin
            rom_we <= 1'b1;
            rom_wdata <= {shreg[23:0], rx_data};
          end
        end
      end
      if (timeout) begin
        byte_cnt <= '0;
        if (byte_cnt != '0) err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_boot_ctrl.sv
// tb_uart_boot_ctrl: directed table-driven bench for uart_boot_ctrl with ADDR_W=2 and short timers
module tb_uart_boot_ctrl;
  localparam int AW = 2;
  localparam int TO = 40;
  localparam int HD = 6;
  logic clk = 0, rst = 1, load_en = 0, rx_valid = 0;
  logic [7:0] rx_data = '0;
  logic rom_we, cpu_rst, busy, err;
  logic [AW-1:0] rom_addr;
  logic [31:0] rom_wdata;
  logic [AW:0] word_cnt;
  int tests = 0, fails = 0;
  int nwr = 0, busy_cnt = 0, crst_cnt = 0;
  int log_a [64];
  logic [31:0] log_d [64];
  typedef struct {
    logic le;
    int nb;
    logic [31:0] w [5];
    int nwr;
    logic err;
    int wcnt;
    int addr;
  } vec_t;
  vec_t tbl [5];

  uart_boot_ctrl #(.ADDR_W(AW), .TIMEOUT(TO), .HOLD(HD)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .rx_valid(rx_valid), .rx_data(rx_data),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata), .cpu_rst(cpu_rst),
    .busy(busy), .word_cnt(word_cnt), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && rom_we && nwr < 64) begin
      log_a[nwr] = int'(rom_addr);
      log_d[nwr] = rom_wdata;
      nwr++;
    end

  always @(negedge clk)
    if (!rst) begin
      if (busy) busy_cnt++;
      if (cpu_rst) crst_cnt++;
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while ((cpu_rst || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic setv(input int i, input logic le, input int nb,
                      input logic [31:0] a, b, c, d, e,
                      input int nw, input logic er, input int wc, input int ad);
    tbl[i].le = le; tbl[i].nb = nb;
    tbl[i].w[0] = a; tbl[i].w[1] = b; tbl[i].w[2] = c; tbl[i].w[3] = d; tbl[i].w[4] = e;
    tbl[i].nwr = nw; tbl[i].err = er; tbl[i].wcnt = wc; tbl[i].addr = ad;
  endtask

  initial begin
    int base, b0, c0, n;
    logic [31:0] w;
    setv(0, 1, 16, 32'h00100093, 32'h00200113, 32'h001080B3, 32'hFE208EE3, 0, 4, 0, 4, 3);
    setv(1, 1, 6, 32'h11223344, 32'h55667788, 0, 0, 0, 1, 1, 1, 1);
    setv(2, 1, 20, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005, 4, 1, 4, 3);
    setv(3, 0, 4, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 4, 3);
    setv(4, 1, 8, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 2, 0, 2, 2);

    repeat (3) @(negedge clk);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_wdata", rom_wdata, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    rst = 0;
    @(negedge clk);
    chk("post_rst_cpu_rst", cpu_rst, 0);

    for (int s = 0; s < 5; s++) begin
      load_en = tbl[s].le;
      base = nwr; b0 = busy_cnt; c0 = crst_cnt;
      for (int i = 0; i < tbl[s].nb; i++) begin
        w = tbl[s].w[i / 4];
        send(w[31 - 8 * (i % 4) -: 8]);
      end
      wait_idle(n);
      if (tbl[s].le) chk($sformatf("v%0d_release_cycles", s), n, TO + HD);
      else begin
        repeat (10) @(negedge clk);
        chk($sformatf("v%0d_no_busy", s), busy_cnt - b0, 0);
        chk($sformatf("v%0d_no_cpu_rst", s), crst_cnt - c0, 0);
      end
      chk($sformatf("v%0d_nwr", s), nwr - base, tbl[s].nwr);
      for (int j = 0; j < tbl[s].nwr; j++) begin
        chk($sformatf("v%0d_addr%0d", s, j), log_a[base + j], j);
        chk($sformatf("v%0d_data%0d", s, j), log_d[base + j], tbl[s].w[j]);
      end
      chk($sformatf("v%0d_err", s), err, tbl[s].err);
      chk($sformatf("v%0d_word_cnt", s), word_cnt, tbl[s].wcnt);
      chk($sformatf("v%0d_rom_addr", s), rom_addr, tbl[s].addr);
      load_en = 1;
    end

    base = nwr;
    send(8'hCA); send(8'hFE); send(8'hF0);
    @(negedge clk);
    rx_valid = 1; rx_data = 8'h0D;
    @(negedge clk);
    chk("coincide_we", rom_we, 1);
    rx_data = 8'h5A;
    @(negedge clk);
    rx_valid = 0;
    send(8'h11); send(8'h22); send(8'h33);
    wait_idle(n);
    chk("coincide_release", n, TO + HD);
    chk("coincide_nwr", nwr - base, 2);
    chk("coincide_d0", log_d[base], 32'hCAFEF00D);
    chk("coincide_d1", log_d[base + 1], 32'h5A112233);
    chk("coincide_a1", log_a[base + 1], 1);
    chk("coincide_err", err, 0);

    base = nwr;
    for (int i = 0; i < 9; i++) send(8'(i + 1));
    rst = 1;
    @(negedge clk);
    chk("midrst_cpu_rst_high", cpu_rst, 1);
    chk("midrst_busy", busy, 0);
    rst = 0;
    #1;
    chk("midrst_cpu_rst_low", cpu_rst, 0);
    chk("midrst_word_cnt", word_cnt, 0);
    repeat (100) @(negedge clk);
    chk("midrst_nwr", nwr - base, 2);
    chk("midrst_d1", log_d[base + 1], 32'h05060708);
    chk("midrst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
